// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit (PC register, imem handshake with timeout, fetch fault)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_ins_addr,
  input  logic        commit,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic        fault
);
  localparam logic [1:0] FETCH = 2'd0, VALID = 2'd1, FAULT = 2'd2;
  logic [1:0] state;
  logic [7:0] wcnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      ins_addr <= RESET_PC;
      instr    <= '0;
      wcnt     <= '0;
      fault    <= 1'b0;
    end else if (state == FETCH) begin
      if (imem_ack) begin
        instr <= imem_rdata;
        wcnt  <= '0;
        state <= VALID;
      end else if (wcnt == TIMEOUT) begin
        state <= FAULT;
        fault <= 1'b1;
      end else begin
        wcnt <= wcnt + 8'd1;
      end
    end else if (state == VALID && commit && !stall) begin
      ins_addr <= next_ins_addr;
      state    <= next_ins_addr[1:0] == 2'b00 ? FETCH : FAULT;
      fault    <= next_ins_addr[1:0] != 2'b00;
    end
  end
  assign imem_req    = state == FETCH;
  assign imem_addr   = ins_addr;
  assign instr_valid = state == VALID;
  assign op          = instr[31:26];
  assign imm16       = instr[15:0];
  assign imm26       = instr[25:0];
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch against a behavioural fetch model
module tb_ifu_fetch;
  localparam int TO = 255;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] next_ins_addr = '0;
  logic        commit = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic        fault;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .next_ins_addr(next_ins_addr), .commit(commit), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins_addr(ins_addr), .instr(instr), .instr_valid(instr_valid), .op(op), .imm16(imm16),
    .imm26(imm26), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        v;
    logic [31:0] ins;
    logic        f;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model: 0 = waiting for memory, 1 = holding an instruction, 2 = faulted
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  int          m_wait;

  function automatic exp_t m_exp();
    exp_t e;
    e.req = (m_mode == 0);
    e.pc  = m_pc;
    e.v   = (m_mode == 1);
    e.ins = m_ins;
    e.f   = (m_mode == 2);
    return e;
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_pc   = 32'h0000_3000;
    m_ins  = 32'h0;
    m_wait = 0;
  endtask

  task automatic m_step(input logic a, input logic [31:0] rd, input logic c, input logic s,
                        input logic [31:0] na);
    if (m_mode == 0) begin
      if (a) begin
        m_ins  = rd;
        m_mode = 1;
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait > TO) m_mode = 2;
      end
    end else if (m_mode == 1 && c && !s) begin
      m_pc   = na;
      m_mode = (na % 4 == 0) ? 0 : 2;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check(input string t, input exp_t e);
    logic [31:0] ei;
    ei = e.ins;
    chk({t, ".imem_req"}, {31'b0, imem_req}, {31'b0, e.req});
    chk({t, ".imem_addr"}, imem_addr, e.pc);
    chk({t, ".ins_addr"}, ins_addr, e.pc);
    chk({t, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e.v});
    chk({t, ".instr"}, instr, ei);
    chk({t, ".op"}, {26'b0, op}, {26'b0, ei[31:26]});
    chk({t, ".imm16"}, {16'b0, imm16}, {16'b0, ei[15:0]});
    chk({t, ".imm26"}, {6'b0, imm26}, {6'b0, ei[25:0]});
    chk({t, ".fault"}, {31'b0, fault}, {31'b0, e.f});
  endtask

  // called at posedge+1: inputs apply to the coming edge, optional async reset pulse before it
  task automatic cyc(input logic a, input logic [31:0] rd, input logic c, input logic s,
                     input logic [31:0] na, input bit pr);
    imem_ack      = a;
    imem_rdata    = rd;
    commit        = c;
    stall         = s;
    next_ins_addr = na;
    if (pr) begin
      @(negedge clk);
      #1 reset = 1'b1;
      m_reset();
      #1 check("async_reset", m_exp());
      #1 reset = 1'b0;
    end
    m_step(a, rd, c, s, na);
    q.push_back(m_exp());
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mon", e);
      end
    end
  end

  initial begin
    logic [31:0] na;
    logic        a, c, s;
    bit          pr;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    q.push_back(m_exp());
    cyc(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) cyc(1'b0, $urandom, 1'b1, 1'b1, 32'h0000_3004, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3004, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom % 3) != 0;
      c  = ($urandom % 2) == 1;
      s  = ($urandom % 4) == 0;
      na = $urandom & ~32'h3;
      if ($urandom % 20 == 0) na = na | (($urandom % 3) + 1);
      pr = (m_mode == 2) ? ($urandom % 4 == 0) : ($urandom % 60 == 0);
      cyc(a, $urandom, c, s, na, pr);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (TO) cyc(1'b0, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) cyc(1'b1, $urandom, 1'b1, 1'b0, 32'h0000_4000, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (TO - 1) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'hABCD_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (9) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (TO) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h0C00_1111, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3006, 1'b0);
    repeat (4) cyc(1'b1, $urandom, 1'b1, 1'b0, 32'h0000_3008, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 32'hFC00_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
    cyc(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 Parameter TIMEOUT, default 8'd255, maximum wait cycles for imem_ack before a fault is raised.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port next_ins_addr  input  32  address of the next instruction, produced by the next-PC stage.
REQ-006 Port commit  input  1  the downstream datapath has consumed the current instruction.
REQ-007 Port stall  input  1  blocks PC advance while high.
REQ-008 Port imem_req  output  1  fetch request to instruction memory.
REQ-009 Port imem_addr  output  32  fetch address.
REQ-010 Port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-011 Port imem_rdata  input  32  instruction word from memory.
REQ-012 Port ins_addr  output  32  current PC; feeds the next-PC stage.
REQ-013 Port instr  output  32  latched instruction word.
REQ-014 Port instr_valid  output  1  instr and ins_addr are valid for the datapath.
REQ-015 Port op, imm16, imm26  output  6/16/26  instr[31:26], instr[15:0] and instr[25:0], respectively.
REQ-016 Port fault  output  1  sticky fetch fault (misaligned address or timeout).

Function
REQ-017 FSM states: FETCH, VALID, FAULT; encoding is free.
REQ-018 FETCH behaviour: imem_req=1, imem_addr=ins_addr, instr_valid=0; the wait counter increments each cycle that imem_ack=0.
REQ-019 FETCH with imem_ack=1: instr<=imem_rdata, wait counter<=0, next state VALID; fetch latency is therefore 1 cycle minimum.
REQ-020 FETCH timeout: when the wait counter equals TIMEOUT and imem_ack=0, the next state is FAULT; an ack arriving in that same cycle wins and the block goes to VALID.
REQ-021 imem_addr shall remain stable while imem_req=1 until ack; imem_ack is ignored while imem_req=0.
REQ-022 VALID behaviour: instr_valid=1, imem_req=0; instr and ins_addr are held.
REQ-023 VALID with commit=1 and stall=0: ins_addr<=next_ins_addr and instr_valid drops next cycle.
  - next_ins_addr[1:0]==0: next state FETCH.
  - otherwise: next state FAULT.
REQ-024 VALID with commit=1 and stall=1: no PC change, remain in VALID; the commit is discarded, and the datapath re-asserts commit later.
REQ-025 FAULT: fault=1, imem_req=0, instr_valid=0, ins_addr holds the offending address; the state is left only by reset.
REQ-026 The PC register is 32 bits and is not masked or wrapped.
  - 32'hFFFF_FFFC followed by next_ins_addr=0 is legal.
REQ-027 op, imm16 and imm26 are combinational slices of the registered instr; they are undefined-free (instr resets to 0).
REQ-028 fault is registered; all other outputs are derived from registered state with no combinational path from inputs.

Reset
REQ-029 Reset forces, asynchronously and at any point (including mid-wait or in FAULT): state=FETCH, ins_addr=RESET_PC, instr=0, wait counter=0, fault=0.
  - Consequently instr_valid=0 and imem_req=1 immediately.
REQ-030 On reset deassertion the first fetch proceeds from RESET_PC with no extra idle cycle.

Verification
REQ-031 Reset, then ack with rdata 32'h2008_0005 on the first cycle -> next cycle ins_addr=32'h0000_3000, instr_valid=1, op=6'b001000, imm16=16'h0005.
REQ-032 VALID, commit=1, stall=0, next_ins_addr=32'h0000_3004 -> next cycle ins_addr=32'h0000_3004, imem_req=1, instr_valid=0.
REQ-033 VALID, commit=1 and stall=1 for 3 cycles -> ins_addr unchanged and instr_valid=1 throughout; releasing stall with commit=1 advances the PC.
REQ-034 FETCH with no ack for TIMEOUT+1 cycles (default: 256 cycles) -> fault=1 and imem_req=0, with ins_addr held.
  - The same run with ack in cycle TIMEOUT+1 (default: cycle 256) -> VALID and no fault.
REQ-035 VALID, commit with next_ins_addr=32'h0000_3006 -> fault=1, ins_addr=32'h0000_3006; the block stays in FAULT until reset.
REQ-036 Reset asserted mid-wait (counter=10) -> outputs revert immediately; after release, imem_addr=32'h0000_3000 and the counter restarts from 0.
